// File: rtl/cache_fill_responder.sv
// Memory-side responder for the cache line-fill port: critical-word-first 4-word
// read bursts and byte-masked word writes over a granted fixed-latency memory port.
// Optional macro CACHE_FILL_SNOOP_EN adds a chip-RAM write invalidate strobe.
module cache_fill_responder #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned MEM_AW     = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sdram_req,
   input  logic              sdram_rw,
   input  logic [31:0]       sdram_addr,
   input  logic [1:0]        crit_word,
   input  logic [15:0]       data_to_sdram,
   input  logic              sdram_wru,
   input  logic              sdram_wrl,
   output logic              sdram_fill,
   output logic [15:0]       data_from_sdram,
   output logic              sdram_wr_ack,
   output logic              busy,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [1:0]        mem_be,
   output logic [15:0]       mem_wdata,
   input  logic              mem_grant,
   input  logic [15:0]       mem_rdata,
   output logic              snoop_req,
   output logic [20:0]       snoop_addr
);
   localparam int unsigned LAST = RD_LATENCY - 1;
   localparam int unsigned IW   = 2 * RD_LATENCY;

   typedef enum logic [2:0] {IDLE, RDCMD, RDWAIT, STREAM, WRCMD, WRACK, HOLD} state_t;
   state_t state, state_nxt;

   logic [31:0]     addr_q, addr_n;
   logic [1:0]      crit_q, crit_n;
   logic [1:0]      be_q, be_n;
   logic [15:0]     wdata_q, wdata_n;
   logic [2:0]      k_q, k_n;
   logic [1:0]      j_q;
   logic [3:0]      buf_v;
   logic [15:0]     line_buf [4];
   logic [LAST:0]   pipe_v;
   logic [IW-1:0]   pipe_idx;
   logic            start, issue_acc, cap_v;
   logic [1:0]      issue_idx, cap_idx, str_idx;

   logic              rd_nxt, wr_nxt, fill_nxt, ack_nxt, busy_nxt;
   logic [MEM_AW-1:0] addr_out_nxt;
   logic [1:0]        be_out_nxt;
   logic [15:0]       wdata_out_nxt, data_nxt;

   assign start     = (state == IDLE) && sdram_req;
   assign issue_acc = (state == RDCMD) && mem_rd && mem_grant;
   assign issue_idx = 2'(crit_q + k_q[1:0]);
   assign cap_v     = pipe_v[LAST] && ((state == RDCMD) || (state == RDWAIT));
   assign cap_idx   = pipe_idx[2*LAST +: 2];
   assign str_idx   = 2'(crit_q + j_q);

   // Request fields are latched only when IDLE accepts a request.
   assign addr_n  = start ? sdram_addr : addr_q;
   assign crit_n  = start ? crit_word : crit_q;
   assign be_n    = start ? {sdram_wru, sdram_wrl} : be_q;
   assign wdata_n = start ? data_to_sdram : wdata_q;
   assign k_n     = start ? 3'd0 : (issue_acc ? 3'(k_q + 3'd1) : k_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sdram_req) state_nxt = sdram_rw ? RDCMD : WRCMD;
         RDCMD:   if (issue_acc && (k_q == 3'd3)) state_nxt = RDWAIT;
         RDWAIT:  if (&buf_v) state_nxt = STREAM;
         STREAM:  if (j_q == 2'd3) state_nxt = HOLD;
         WRCMD:   if ((be_q == 2'b00) || (mem_wr && mem_grant)) state_nxt = WRACK;
         WRACK:   state_nxt = HOLD;
         HOLD:    if (!sdram_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory commands track the next state; cache-side outputs lag the state by one.
   always_comb begin
      rd_nxt        = (state_nxt == RDCMD);
      wr_nxt        = (state_nxt == WRCMD) && (be_n != 2'b00);
      addr_out_nxt  = mem_addr;
      be_out_nxt    = mem_be;
      wdata_out_nxt = mem_wdata;
      data_nxt      = data_from_sdram;
      fill_nxt      = (state == STREAM) && (j_q == 2'd0);
      ack_nxt       = (state == WRACK);
      busy_nxt      = (state_nxt != IDLE);
      if (rd_nxt) addr_out_nxt = {addr_n[MEM_AW:3], 2'(crit_n + k_n[1:0])};
      if (wr_nxt) begin
         addr_out_nxt  = addr_n[MEM_AW:1];
         be_out_nxt    = be_n;
         wdata_out_nxt = wdata_n;
      end
      if (state == STREAM) data_nxt = line_buf[str_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_rd          <= 1'b0;
         mem_wr          <= 1'b0;
         mem_addr        <= '0;
         mem_be          <= 2'b00;
         mem_wdata       <= 16'd0;
         data_from_sdram <= 16'd0;
         sdram_fill      <= 1'b0;
         sdram_wr_ack    <= 1'b0;
         busy            <= 1'b0;
      end else begin
         mem_rd          <= rd_nxt;
         mem_wr          <= wr_nxt;
         mem_addr        <= addr_out_nxt;
         mem_be          <= be_out_nxt;
         mem_wdata       <= wdata_out_nxt;
         data_from_sdram <= data_nxt;
         sdram_fill      <= fill_nxt;
         sdram_wr_ack    <= ack_nxt;
         busy            <= busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= 32'd0;
         crit_q  <= 2'd0;
         be_q    <= 2'b00;
         wdata_q <= 16'd0;
         k_q     <= 3'd0;
         j_q     <= 2'd0;
         buf_v   <= 4'd0;
      end else begin
         addr_q  <= addr_n;
         crit_q  <= crit_n;
         be_q    <= be_n;
         wdata_q <= wdata_n;
         k_q     <= k_n;
         j_q     <= (state == STREAM) ? 2'(j_q + 2'd1) : 2'd0;
         if (start)      buf_v          <= 4'd0;
         else if (cap_v) buf_v[cap_idx] <= 1'b1;
      end
   end

   // Return pipe: one valid/index slot per cycle of read latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_v   <= '0;
         pipe_idx <= '0;
      end else begin
         pipe_v   <= (pipe_v << 1) | RD_LATENCY'(issue_acc);
         pipe_idx <= (pipe_idx << 2) | IW'(issue_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (cap_v) line_buf[cap_idx] <= mem_rdata;
   end

`ifdef CACHE_FILL_SNOOP_EN
   logic chip_ram_wr;
   assign chip_ram_wr = (state == WRACK) && (addr_q[31:21] == 11'd0) && (be_q != 2'b00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snoop_req  <= 1'b0;
         snoop_addr <= 21'd0;
      end else begin
         snoop_req <= chip_ram_wr;
         if (chip_ram_wr) snoop_addr <= addr_q[20:0];
      end
   end
`else
   logic addr_unused;
   assign addr_unused = ^{addr_q[31:MEM_AW+1], addr_q[0]};
   assign snoop_req   = 1'b0;
   assign snoop_addr  = 21'd0;
`endif

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed bench for cache_fill_responder: critical-word-first reads, grant stalls,
// byte-masked writes, held requests, mid-read reset and the optional snoop strobe.
module tb_cache_fill_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        sdram_req, sdram_rw, sdram_wru, sdram_wrl;
   logic [31:0] sdram_addr;
   logic [1:0]  crit_word;
   logic [15:0] data_to_sdram;
   logic        sdram_fill, sdram_wr_ack, busy;
   logic [15:0] data_from_sdram;
   logic [23:0] mem_addr;
   logic        mem_rd, mem_wr, mem_grant;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata, mem_rdata;
   logic        snoop_req;
   logic [20:0] snoop_addr;

   cache_fill_responder #(.RD_LATENCY(2), .MEM_AW(24)) dut (
      .clk(clk), .reset(reset),
      .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr),
      .crit_word(crit_word), .data_to_sdram(data_to_sdram),
      .sdram_wru(sdram_wru), .sdram_wrl(sdram_wrl),
      .sdram_fill(sdram_fill), .data_from_sdram(data_from_sdram),
      .sdram_wr_ack(sdram_wr_ack), .busy(busy),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_grant(mem_grant), .mem_rdata(mem_rdata),
      .snoop_req(snoop_req), .snoop_addr(snoop_addr)
   );

   always #5 clk = ~clk;

   // Fixed two-cycle-latency memory: data appears two cycles after the accept cycle.
   logic [15:0] mem_model [256];
   logic        rv0 = 1'b0, rv1 = 1'b0;
   logic [7:0]  ra0 = 8'd0, ra1 = 8'd0;
   always @(posedge clk) begin
      rv0 <= mem_rd && mem_grant;
      ra0 <= mem_addr[7:0];
      rv1 <= rv0;
      ra1 <= ra0;
   end
   assign mem_rdata = rv1 ? mem_model[ra1] : 16'hDEAD;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Per-cycle log of one transaction; index c is the cycle after the c-th edge
   // following the edge on which IDLE samples the request.
   logic [15:0] gpat;
   int          glen;
   logic [63:0] fill_v, ack_v, busy_v, snoop_v;
   logic [15:0] dlog [64];
   logic [23:0] rdq [$];
   int          wr_n;
   logic [23:0] wr_addr;
   logic [1:0]  wr_be;
   logic [15:0] wr_data;
   logic [20:0] snoop_a;

   task automatic run(input int n, input int rel_at);
      fill_v = '0; ack_v = '0; busy_v = '0; snoop_v = '0;
      rdq.delete();
      wr_n = 0; wr_addr = '0; wr_be = '0; wr_data = '0; snoop_a = '0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         mem_grant = (c < glen) ? gpat[c] : 1'b1;
         if (mem_rd && mem_grant) rdq.push_back(mem_addr);
         if (mem_wr) begin
            if (wr_n == 0) begin
               wr_addr = mem_addr; wr_be = mem_be; wr_data = mem_wdata;
            end
            wr_n++;
         end
         fill_v[c]  = sdram_fill;
         ack_v[c]   = sdram_wr_ack;
         busy_v[c]  = busy;
         snoop_v[c] = snoop_req;
         dlog[c]    = data_from_sdram;
         if (snoop_req) snoop_a = snoop_addr;
         if (rel_at < 0 ? (sdram_fill || sdram_wr_ack) : (c == rel_at)) sdram_req = 1'b0;
      end
   endtask

   task automatic issue(input logic rw, input logic [31:0] a, input logic [1:0] cw,
                        input logic [15:0] d, input logic wu, input logic wl);
      sdram_req = 1'b1; sdram_rw = rw; sdram_addr = a; crit_word = cw;
      data_to_sdram = d; sdram_wru = wu; sdram_wrl = wl;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         mem_model[i]     = 16'h00A0 + 16'(i);
         mem_model[4 + i] = 16'h00B0 + 16'(i);
         mem_model[8 + i] = 16'h00C0 + 16'(i);
      end
      reset = 1'b0; mem_grant = 1'b1; gpat = '0; glen = 0;
      issue(1'b0, 32'd0, 2'd0, 16'd0, 1'b0, 1'b0);
      sdram_req = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_flags", {busy, mem_rd, mem_wr, sdram_fill, sdram_wr_ack, snoop_req}, 96'd0);
      check_eq("reset_data", {data_from_sdram, mem_wdata, mem_addr, mem_be, snoop_addr}, 96'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", busy, 96'd0);

      // Read 0x200, critical word 2, grant always high
      issue(1'b1, 32'h200, 2'd2, 16'd0, 1'b0, 1'b0);
      run(16, -1);
      check_eq("rd1_cmds", rdq.size(), 96'd4);
      if (rdq.size() == 4) begin
         check_eq("rd1_addr0", rdq[0], 96'h102);
         check_eq("rd1_addr1", rdq[1], 96'h103);
         check_eq("rd1_addr2", rdq[2], 96'h100);
         check_eq("rd1_addr3", rdq[3], 96'h101);
      end
      check_eq("rd1_fill", fill_v, 96'h100);
      check_eq("rd1_d0", dlog[8],  96'hA2);
      check_eq("rd1_d1", dlog[9],  96'hA3);
      check_eq("rd1_d2", dlog[10], 96'hA0);
      check_eq("rd1_d3", dlog[11], 96'hA1);
      check_eq("rd1_idle", busy_v[15], 96'd0);

      // Read 0x208, critical word 1, grant pattern 1,0,0,1,0,1,1
      gpat = 16'b1101001; glen = 7;
      issue(1'b1, 32'h208, 2'd1, 16'd0, 1'b0, 1'b0);
      run(20, -1);
      glen = 0;
      check_eq("rd2_cmds", rdq.size(), 96'd4);
      if (rdq.size() == 4) begin
         check_eq("rd2_addr0", rdq[0], 96'h105);
         check_eq("rd2_addr3", rdq[3], 96'h104);
      end
      check_eq("rd2_fill", fill_v, 96'h800);
      check_eq("rd2_d0", dlog[11], 96'hB1);
      check_eq("rd2_d1", dlog[12], 96'hB2);
      check_eq("rd2_d2", dlog[13], 96'hB3);
      check_eq("rd2_d3", dlog[14], 96'hB0);

      // Upper-byte write, grant on the third command cycle
      gpat = 16'b100; glen = 3;
      issue(1'b0, 32'h1234, 2'd0, 16'hBEEF, 1'b1, 1'b0);
      run(8, -1);
      glen = 0;
      check_eq("wr_hold", wr_n, 96'd3);
      check_eq("wr_addr", wr_addr, 96'h91A);
      check_eq("wr_be", wr_be, 96'b10);
      check_eq("wr_data", wr_data, 96'hBEEF);
      check_eq("wr_ack", ack_v, 96'h10);

      // No byte enables: no memory write, ack two cycles after the sampled request
      issue(1'b0, 32'h40, 2'd0, 16'h5555, 1'b0, 1'b0);
      run(6, -1);
      check_eq("wr0_cmds", wr_n, 96'd0);
      check_eq("wr0_ack", ack_v, 96'h4);

      // Request held ten cycles past the ack is serviced once
      issue(1'b0, 32'h80, 2'd0, 16'h1111, 1'b1, 1'b1);
      run(16, 12);
      check_eq("hold_cmds", wr_n, 96'd1);
      check_eq("hold_ack", ack_v, 96'h4);
      check_eq("hold_busy_req", busy_v[12], 96'd1);
      check_eq("hold_busy_idle", busy_v[13], 96'd0);

      // Reset in RDWAIT with two returns still in flight
      issue(1'b1, 32'h200, 2'd0, 16'd0, 1'b0, 1'b0);
      run(4, 99);
      @(negedge clk);
      check_eq("rst_pre_busy", busy, 96'd1);
      reset = 1'b0; sdram_req = 1'b0;
      #1;
      check_eq("rst_flags", {busy, mem_rd, mem_wr, sdram_fill, sdram_wr_ack, snoop_req}, 96'd0);
      check_eq("rst_data", {data_from_sdram, mem_wdata, mem_addr, mem_be, snoop_addr}, 96'd0);
      @(negedge clk);
      reset = 1'b1;
      issue(1'b1, 32'h210, 2'd3, 16'd0, 1'b0, 1'b0);
      run(16, -1);
      check_eq("rst_rd_fill", fill_v, 96'h100);
      check_eq("rst_rd_d0", dlog[8],  96'hC3);
      check_eq("rst_rd_d1", dlog[9],  96'hC0);
      check_eq("rst_rd_d2", dlog[10], 96'hC1);
      check_eq("rst_rd_d3", dlog[11], 96'hC2);

      // Chip-RAM write: snoop strobe only when the feature is built in
      issue(1'b0, 32'h1F0, 2'd0, 16'h1234, 1'b1, 1'b1);
      run(6, -1);
      check_eq("snp_ack", ack_v, 96'h4);
`ifdef CACHE_FILL_SNOOP_EN
      check_eq("snp_req", snoop_v, 96'h4);
      check_eq("snp_addr", snoop_a, 96'h1F0);
`else
      check_eq("snp_req", snoop_v, 96'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cache_fill_responder.md
Name: cache_fill_responder

Overview:
- Memory-side responder for the CPU cache line-fill interface.
- Accepts read-line and single-word write requests from the two-way cache on the sdram_* handshake.
- Fetches 4-word lines from a granted, fixed-latency 16-bit memory port.
- Returns each line critical-word-first on 4 consecutive cycles, with a one-cycle sdram_fill strobe on the first word.

Parameters:
- RD_LATENCY, 2, cycles from an accepted mem_rd to valid mem_rdata; legal range 1..4.
- MEM_AW, 24, memory word-address width; mem_addr = sdram_addr[MEM_AW:1].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- sdram_req  in  1  request from cache; held until fill or ack
- sdram_rw  in  1  1 = line read, 0 = word write
- sdram_addr  in  32  byte address; line aligned for reads
- crit_word  in  2  index of the first word to return
- data_to_sdram  in  16  write data
- sdram_wru  in  1  upper-byte write enable
- sdram_wrl  in  1  lower-byte write enable
- sdram_fill  out  1  one-cycle strobe with the first (critical) word
- data_from_sdram  out  16  burst data, registered
- sdram_wr_ack  out  1  one-cycle write-complete pulse
- busy  out  1  high in any state except IDLE
- mem_addr  out  MEM_AW  memory word address
- mem_rd  out  1  read command, held until granted
- mem_wr  out  1  write command, held until granted
- mem_be  out  2  {upper, lower} byte enables
- mem_wdata  out  16  write data
- mem_grant  in  1  command accepted this cycle when high with mem_rd or mem_wr
- mem_rdata  in  16  valid RD_LATENCY cycles after each accepted read
- snoop_req  out  1  invalidate strobe toward the cache
- snoop_addr  out  21  chip-RAM address for invalidation

Behaviour:
- Reset (asynchronous) forces all outputs to 0 and the state to IDLE. It clears the return pipeline and the line buffer valid bits. Any in-flight read data is discarded.
- IDLE:
  - sdram_req=1 with sdram_rw=1: latch address and crit_word, k=0, go to RDCMD.
  - sdram_req=1 with sdram_rw=0: latch address, data and byte enables, go to WRCMD.
- RDCMD:
  - mem_rd=1, mem_addr = {latched_addr[MEM_AW:3], (crit_word+k) mod 4}.
  - On each grant, k increments and the index is pushed into an RD_LATENCY-deep valid/index shift pipe.
  - After the 4th grant, go to RDWAIT.
- Read capture: when the pipe output is valid, mem_rdata is written to buf[index]. Capture runs in RDCMD and RDWAIT, overlapping with issue.
- RDWAIT: hold until all 4 words are captured, then go to STREAM.
- STREAM, 4 cycles, j=0..3:
  - data_from_sdram = buf[(crit_word+j) mod 4].
  - sdram_fill=1 only at j=0.
  - After j=3, go to HOLD.
  - Words are strictly back-to-back; the cache cannot stall.
- WRCMD:
  - mem_wr=1, mem_be={wru,wrl}, mem_wdata = latched data.
  - On grant, go to WRACK.
  - If both byte enables are 0, no mem_wr is issued and the state goes directly to WRACK.
- WRACK: sdram_wr_ack=1 for one cycle, then go to HOLD.
- HOLD: wait for sdram_req=0, then go to IDLE. This prevents a request still held high from being serviced twice.
- sdram_req falling mid-burst does not abort; the burst completes.
- With mem_grant tied to 1, sdram_fill asserts exactly 6+RD_LATENCY cycles after the edge on which IDLE samples sdram_req=1.
- mem_grant low stalls command issue only; pipelined returns are still captured.
- data_from_sdram holds its last value outside STREAM.

Optional Feature:
- Macro: CACHE_FILL_SNOOP_EN.
- Defined: in the WRACK cycle, snoop_req=1 for one cycle and snoop_addr = latched sdram_addr[20:0].
  - Only if latched sdram_addr[31:21]==0 (chip RAM) and at least one byte enable was set.
  - Lets a second cache sharing the memory invalidate stale lines.
- Not defined: snoop_req and snoop_addr are tied to 0.

Test Plan:
- Read, grant=1, RD_LATENCY=2: memory words 0x000100..0x000103 hold 0xA0,0xA1,0xA2,0xA3; request sdram_addr=0x200, crit_word=2.
  - mem_addr sequence 0x102,0x103,0x100,0x101.
  - fill exactly 8 cycles after the sampled req.
  - data 0xA2,0xA3,0xA0,0xA1 on consecutive cycles; fill high only with 0xA2.
- Read with mem_grant toggling 1,0,0,1,0,1,1: exactly 4 granted mem_rd; no command lost or duplicated; burst still 4 contiguous cycles in correct order.
- Write sdram_addr=0x1234, data 0xBEEF, wru=1, wrl=0, grant delayed 3 cycles:
  - mem_wr held 3 cycles with mem_be=2'b10, mem_addr=0x91A.
  - sdram_wr_ack single pulse one cycle after grant.
- Both byte enables 0 -> no mem_wr; sdram_wr_ack pulses 2 cycles after the sampled req.
- Hold sdram_req high for 10 cycles after ack or burst completion -> no second request serviced; IDLE reached one cycle after req drops.
- Assert reset during RDWAIT with 2 returns pending -> all outputs 0 immediately; the next read returns correct data with no stale capture. With CACHE_FILL_SNOOP_EN, write to 0x001F0 -> snoop_req pulse with snoop_addr=0x001F0.
